m68k_bus_master: RTL
====================

Name: m68k_bus_master

Overview:
- 68000-style bus initiator that drives the CPU side of the MCU bus interface: AS_N, UDS_N, LDS_N, RW, FC, A, data out, and VMA_N/E for 6800-style peripherals.
- It turns single-word transaction requests into S0–S7 bus cycles, paced by the 8 MHz phase enables from clockgen.
- It terminates each cycle on DTACK_N, BERR_N or VPA_N.
- It serves as the CPU model in the system bench and as the bus source for non-CPU FPGA masters.

Parameters:
- ECLK_DIV, 10: 8 MHz cycles per E period.
- ECLK_HIGH, 4: 8 MHz cycles E is high (at the end of the period).
- VMA_ASSERT_CNT, 3: E counter value at which VMA_N is asserted.
- WAIT_MAX, 255: wait-state samples before a watchdog abort (must exceed the 64-cycle BERR timeout).

Ports:
- clk32 in 1: 32 MHz system clock.
- porb in 1: asynchronous active-low reset.
- mhz8_en1 in 1: 8 MHz rising-edge phase enable (even states begin).
- mhz8_en2 in 1: 8 MHz falling-edge phase enable (odd states begin).
- req in 1: transaction request, level.
- req_rw in 1: 1 = read, 0 = write.
- req_fc in 3: function code.
- req_addr in 23: word address A[23:1].
- req_uds in 1: upper byte strobe enable.
- req_lds in 1: lower byte strobe enable.
- req_wdata in 16: write data.
- busy out 1: cycle in progress.
- done out 1: one-clk32 pulse, cycle finished.
- done_berr out 1: qualifies done; cycle ended by bus error or watchdog.
- done_vpa out 1: qualifies done; cycle ended via VPA.
- rdata out 16: read data.
- AS_N out 1: address strobe.
- UDS_N out 1: upper data strobe.
- LDS_N out 1: lower data strobe.
- RW out 1: read/write.
- FC out 3: function code.
- A out 23: address bus A[23:1].
- DOUT out 16: data out.
- DOE out 1: data output enable.
- VMA_N out 1: valid memory address.
- E out 1: 6800 E clock.
- DIN in 16: data in.
- DTACK_N in 1: data transfer acknowledge.
- BERR_N in 1: bus error.
- VPA_N in 1: valid peripheral address.

Behaviour:
- Clock and reset: one clock, clk32; porb is an asynchronous active-low reset.
- Reset values: AS_N=UDS_N=LDS_N=RW=VMA_N=1; E=0; DOE=0; A=0; FC=0; DOUT=0; rdata=0; busy=done=done_berr=done_vpa=0; state IDLE; E counter 0.
- porb low mid-cycle negates all strobes immediately. No done pulse is produced.
- Edge rules:
  - State advances only on enables.
  - Even states S0/S2/S4/S6 are entered on mhz8_en1.
  - Odd states and the wait state are entered on mhz8_en2.
- Request handshake:
  - req is sampled only on mhz8_en1 while in IDLE.
  - The request is captured into internal registers at S0 entry, and busy rises there.
  - Requester holds req until busy=1. req is ignored while busy.
- S0: drive A, FC; RW=1, AS_N=1.
- S1: no output change.
- S2: AS_N=0.
  - Read: UDS_N/LDS_N = ~req_uds/~req_lds.
  - Write: RW=0.
- S3: write only, DOE=1 and DOUT=wdata.
- S4: write only, assert UDS_N/LDS_N.
- Termination sampling (mhz8_en2 ending S4, and each subsequent mhz8_en2 while waiting), priority BERR_N > DTACK_N > VPA_N:
  - BERR_N=0: go to S5 with berr flag set.
  - DTACK_N=0: go to S5.
  - VPA_N=0: go to VPA_SYNC.
  - None asserted: go to WAIT, increment the wait counter, resample on the next mhz8_en2.
  - Wait counter reaching WAIT_MAX: abort as berr.
- S5 → S6 (mhz8_en1) → S7 (mhz8_en2):
  - At S7 entry, latch DIN into rdata for reads when not berr.
  - Also at S7 entry, negate AS_N, UDS_N and LDS_N.
- End of S7 (mhz8_en1):
  - RW=1, DOE=0; A and FC hold their last values.
  - Pulse done with done_berr/done_vpa valid in the same clk32 cycle; busy=0.
  - If req=1 on that same en1, enter S0 directly (back-to-back, no idle phase).
- E counter:
  - Free-running 0..ECLK_DIV-1, advances on mhz8_en1.
  - E=1 when cnt >= ECLK_DIV-ECLK_HIGH.
- VPA path:
  - In VPA_SYNC, on the mhz8_en1 where cnt==VMA_ASSERT_CNT, set VMA_N=0.
  - If that count has already passed, wait for the next E period.
  - On the mhz8_en1 where cnt wraps ECLK_DIV-1→0 (E falling), latch rdata (reads) and go to S7 with done_vpa set.
  - VMA_N negates together with AS_N.
- Simultaneous BERR_N+DTACK_N: berr wins, and rdata is unchanged.
- Interrupt acknowledge: req_fc=7 with req_addr={20'hFFFFF, level}. Treated as an ordinary read; the vector is returned in rdata[7:0]. VPA termination = autovector.

Decomposition:
- Shared package mcu_bus_pkg:
  - state enum (IDLE, S0–S7, WAIT, VPA_SYNC);
  - FC constants (FC_UDATA=1, FC_UPROG=2, FC_SDATA=5, FC_SPROG=6, FC_IACK=7);
  - IACK address base constant.
- One sub-module, eclk_gen: E divider with parameters ECLK_DIV/ECLK_HIGH. Outputs E, the counter value and a wrap pulse.

Test Plan:
- Read from 0x000000 (req_fc=6) with DTACK_N=0 at S2 → exactly 8 phase-ticks from S0 to done; AS_N low from S2 to S7; rdata equals DIN=0x601E.
- Word write to FF8240 with DTACK_N delayed by 2 mhz8_en2 samples → exactly 2 WAIT states; UDS_N/LDS_N low from S4; DOUT=0x0777 with DOE=1 from S3; done_berr=0.
- Read with no DTACK_N, BERR_N low after 64 8 MHz cycles → done with done_berr=1; rdata keeps its previous value; strobes negated at S7.
- Read FFFC02 with VPA_N=0 → VMA_N asserts at E cnt=3; rdata captured at E falling; done_vpa=1; total cycle length depends on E phase, between 10 and 20 8 MHz cycles.
- IACK req_fc=7, level 4, VPA_N=0 → A=0x7FFFFC (A[3:1]=100), FC=7, completes as autovector with done_vpa=1.
- porb low during WAIT → AS_N/UDS_N/LDS_N/RW return to 1 immediately; no done pulse; a new req after release starts cleanly at S0.

Source files
------------

// File: rtl/mcu_bus_pkg.sv
// Shared definitions for the MCU bus: bus-master states, function codes and
// the interrupt-acknowledge address layout.
package mcu_bus_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_S0       = 4'd1,
        ST_S1       = 4'd2,
        ST_S2       = 4'd3,
        ST_S3       = 4'd4,
        ST_S4       = 4'd5,
        ST_S5       = 4'd6,
        ST_S6       = 4'd7,
        ST_S7       = 4'd8,
        ST_WAIT     = 4'd9,
        ST_VPA_SYNC = 4'd10
    } state_t;

    localparam logic [2:0] FC_UDATA = 3'd1;
    localparam logic [2:0] FC_UPROG = 3'd2;
    localparam logic [2:0] FC_SDATA = 3'd5;
    localparam logic [2:0] FC_SPROG = 3'd6;
    localparam logic [2:0] FC_IACK  = 3'd7;

    localparam logic [19:0] IACK_ADDR_BASE = 20'hFFFFF;

    // Request fields held for the duration of one bus cycle.
    typedef struct packed {
        logic        rw;
        logic        uds;
        logic        lds;
        logic [15:0] wdata;
    } bus_req_t;

    function automatic logic [22:0] iack_addr(input logic [2:0] level);
        return {IACK_ADDR_BASE, level};
    endfunction

endpackage

// File: rtl/eclk_gen.sv
// 6800-style E clock divider: free-running counter advanced by tick_en, E high
// for the last ECLK_HIGH counts of each period, wrap marks the E falling edge.
module eclk_gen #(
    parameter int ECLK_DIV  = 10,
    parameter int ECLK_HIGH = 4,
    parameter int CNT_W     = $clog2(ECLK_DIV)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick_en,
    output logic             e,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             e_q, e_d;
    logic             last_s;

    assign last_s = (cnt_q == CNT_W'(ECLK_DIV - 1));

    // Next counter value and E level derived from it, so E tracks the counter.
    always_comb begin
        if (tick_en) begin
            cnt_d = last_s ? {CNT_W{1'b0}} : cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
        e_d = (cnt_d >= CNT_W'(ECLK_DIV - ECLK_HIGH));
    end

    // Counter and E registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {CNT_W{1'b0}};
            e_q   <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            e_q   <= e_d;
        end
    end

    assign e    = e_q;
    assign cnt  = cnt_q;
    assign wrap = tick_en && last_s;

endmodule

// File: rtl/m68k_bus_master.sv
// 68000-style bus initiator: runs one S0..S7 word cycle per request, paced by
// the 8 MHz phase enables, ending on DTACK_N, BERR_N, VPA_N or a watchdog.
module m68k_bus_master
    import mcu_bus_pkg::*;
#(
    parameter int ECLK_DIV       = 10,
    parameter int ECLK_HIGH      = 4,
    parameter int VMA_ASSERT_CNT = 3,
    parameter int WAIT_MAX       = 255
) (
    input  logic        clk32,
    input  logic        porb,
    input  logic        mhz8_en1,
    input  logic        mhz8_en2,
    input  logic        req,
    input  logic        req_rw,
    input  logic [2:0]  req_fc,
    input  logic [22:0] req_addr,
    input  logic        req_uds,
    input  logic        req_lds,
    input  logic [15:0] req_wdata,
    output logic        busy,
    output logic        done,
    output logic        done_berr,
    output logic        done_vpa,
    output logic [15:0] rdata,
    output logic        AS_N,
    output logic        UDS_N,
    output logic        LDS_N,
    output logic        RW,
    output logic [2:0]  FC,
    output logic [22:0] A,
    output logic [15:0] DOUT,
    output logic        DOE,
    output logic        VMA_N,
    output logic        E,
    input  logic [15:0] DIN,
    input  logic        DTACK_N,
    input  logic        BERR_N,
    input  logic        VPA_N
);

    localparam int CNT_W  = $clog2(ECLK_DIV);
    localparam int WAIT_W = $clog2(WAIT_MAX + 1);

    state_t            state_q, state_d;
    bus_req_t          cur_q, cur_d;
    logic              berr_q, berr_d, vpa_q, vpa_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              as_n_q, as_n_d, uds_n_q, uds_n_d, lds_n_q, lds_n_d;
    logic              rw_q, rw_d, doe_q, doe_d, vma_n_q, vma_n_d;
    logic [2:0]        fc_q, fc_d;
    logic [22:0]       a_q, a_d;
    logic [15:0]       dout_q, dout_d, rdata_q, rdata_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic              done_berr_q, done_berr_d, done_vpa_q, done_vpa_d;
    logic              start_s, e_wrap_s;
    logic [CNT_W-1:0]  e_cnt_s;

    eclk_gen #(
        .ECLK_DIV  (ECLK_DIV),
        .ECLK_HIGH (ECLK_HIGH),
        .CNT_W     (CNT_W)
    ) u_eclk (
        .clk     (clk32),
        .rst_n   (porb),
        .tick_en (mhz8_en1),
        .e       (E),
        .cnt     (e_cnt_s),
        .wrap    (e_wrap_s)
    );

    // Bus-cycle sequencer: state transitions and next values of every bus output.
    always_comb begin
        state_d     = state_q;
        berr_d      = berr_q;
        vpa_d       = vpa_q;
        wait_cnt_d  = wait_cnt_q;
        as_n_d      = as_n_q;
        uds_n_d     = uds_n_q;
        lds_n_d     = lds_n_q;
        rw_d        = rw_q;
        doe_d       = doe_q;
        vma_n_d     = vma_n_q;
        fc_d        = fc_q;
        a_d         = a_q;
        dout_d      = dout_q;
        rdata_d     = rdata_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        done_berr_d = 1'b0;
        done_vpa_d  = 1'b0;
        start_s     = 1'b0;
        case (state_q)
            ST_IDLE: start_s = mhz8_en1 && req;
            ST_S0: begin
                if (mhz8_en2) state_d = ST_S1;
                else          state_d = ST_S0;
            end
            ST_S1: begin
                if (mhz8_en1) begin
                    state_d = ST_S2;
                    as_n_d  = 1'b0;
                    rw_d    = cur_q.rw;
                    uds_n_d = cur_q.rw ? ~cur_q.uds : 1'b1;
                    lds_n_d = cur_q.rw ? ~cur_q.lds : 1'b1;
                end else begin
                    state_d = ST_S1;
                end
            end
            ST_S2: begin
                if (mhz8_en2) begin
                    state_d = ST_S3;
                    doe_d   = ~cur_q.rw;
                    dout_d  = cur_q.rw ? dout_q : cur_q.wdata;
                end else begin
                    state_d = ST_S2;
                end
            end
            ST_S3: begin
                // Reads already drive these values; writes assert them here.
                if (mhz8_en1) begin
                    state_d = ST_S4;
                    uds_n_d = ~cur_q.uds;
                    lds_n_d = ~cur_q.lds;
                end else begin
                    state_d = ST_S3;
                end
            end
            ST_S4, ST_WAIT: begin
                if (!mhz8_en2) begin
                    state_d = state_q;
                end else if (!BERR_N) begin
                    state_d = ST_S5;
                    berr_d  = 1'b1;
                end else if (!DTACK_N) begin
                    state_d = ST_S5;
                end else if (!VPA_N) begin
                    state_d = ST_VPA_SYNC;
                end else if (wait_cnt_q == WAIT_W'(WAIT_MAX)) begin
                    state_d = ST_S5;
                    berr_d  = 1'b1;
                end else begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            ST_S5: begin
                if (mhz8_en1) state_d = ST_S6;
                else          state_d = ST_S5;
            end
            ST_S6: begin
                if (mhz8_en2) begin
                    state_d = ST_S7;
                    rdata_d = (cur_q.rw && !berr_q) ? DIN : rdata_q;
                    as_n_d  = 1'b1;
                    uds_n_d = 1'b1;
                    lds_n_d = 1'b1;
                    vma_n_d = 1'b1;
                end else begin
                    state_d = ST_S6;
                end
            end
            ST_VPA_SYNC: begin
                // VMA_N must already be low, so a late start waits a full E period.
                if (mhz8_en1 && e_wrap_s && !vma_n_q) begin
                    state_d = ST_S7;
                    vpa_d   = 1'b1;
                    rdata_d = cur_q.rw ? DIN : rdata_q;
                    as_n_d  = 1'b1;
                    uds_n_d = 1'b1;
                    lds_n_d = 1'b1;
                    vma_n_d = 1'b1;
                end else if (mhz8_en1 && (e_cnt_s == CNT_W'(VMA_ASSERT_CNT))) begin
                    vma_n_d = 1'b0;
                end else begin
                    state_d = ST_VPA_SYNC;
                end
            end
            ST_S7: begin
                if (mhz8_en1) begin
                    state_d     = ST_IDLE;
                    rw_d        = 1'b1;
                    doe_d       = 1'b0;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    done_berr_d = berr_q;
                    done_vpa_d  = vpa_q;
                    start_s     = req;
                end else begin
                    state_d = ST_S7;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (start_s) begin
            state_d    = ST_S0;
            cur_d      = '{rw: req_rw, uds: req_uds, lds: req_lds, wdata: req_wdata};
            busy_d     = 1'b1;
            a_d        = req_addr;
            fc_d       = req_fc;
            rw_d       = 1'b1;
            as_n_d     = 1'b1;
            berr_d     = 1'b0;
            vpa_d      = 1'b0;
            wait_cnt_d = {WAIT_W{1'b0}};
        end else begin
            cur_d = cur_q;
        end
    end

    // State and output registers; reset negates every strobe at once.
    always_ff @(posedge clk32 or negedge porb) begin
        if (!porb) begin
            state_q     <= ST_IDLE;
            cur_q       <= '0;
            berr_q      <= 1'b0;
            vpa_q       <= 1'b0;
            wait_cnt_q  <= {WAIT_W{1'b0}};
            as_n_q      <= 1'b1;
            uds_n_q     <= 1'b1;
            lds_n_q     <= 1'b1;
            rw_q        <= 1'b1;
            doe_q       <= 1'b0;
            vma_n_q     <= 1'b1;
            fc_q        <= 3'd0;
            a_q         <= 23'd0;
            dout_q      <= 16'd0;
            rdata_q     <= 16'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            done_berr_q <= 1'b0;
            done_vpa_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            berr_q      <= berr_d;
            vpa_q       <= vpa_d;
            wait_cnt_q  <= wait_cnt_d;
            as_n_q      <= as_n_d;
            uds_n_q     <= uds_n_d;
            lds_n_q     <= lds_n_d;
            rw_q        <= rw_d;
            doe_q       <= doe_d;
            vma_n_q     <= vma_n_d;
            fc_q        <= fc_d;
            a_q         <= a_d;
            dout_q      <= dout_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            done_berr_q <= done_berr_d;
            done_vpa_q  <= done_vpa_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign done_berr = done_berr_q;
    assign done_vpa  = done_vpa_q;
    assign rdata     = rdata_q;
    assign AS_N      = as_n_q;
    assign UDS_N     = uds_n_q;
    assign LDS_N     = lds_n_q;
    assign RW        = rw_q;
    assign FC        = fc_q;
    assign A         = a_q;
    assign DOUT      = dout_q;
    assign DOE       = doe_q;
    assign VMA_N     = vma_n_q;

endmodule
